pt_tx_sched: RTL
================

Name: pt_tx_sched

Overview:
Transmission scheduler between the 24-bit code-word assembler (pipo_8_to_24) and the PT2262 encoder (pt_enc). Buffers assembled code words in a small FIFO and launches each word into the encoder a configurable number of times, as PT2262 receivers require repeated frames. Inserts a fixed inter-frame gap between launches and back-pressures the assembler when the FIFO is full.

Parameters:
DEPTH, 4, FIFO depth in code words; power of 2, minimum 2.
DEF_REPEATS, 4, launches per word when cfg_repeats is 0.
GAP_CYCLES, 32, idle clocks between consecutive launches; minimum 1.
START_TIMEOUT, 64, clocks allowed for enc_done to fall after enc_ld.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  one-cycle strobe from the assembler: in_data holds a complete word.
in_data  input  24  code word to enqueue.
in_ready  output  1  FIFO not full.
cfg_repeats  input  4  launches per word; 0 selects DEF_REPEATS; sampled at dequeue.
enc_ld  output  1  one-cycle load strobe to pt_enc.
enc_ad  output  24  word to pt_enc; held stable from LOAD until the next dequeue.
enc_done  input  1  encoder idle/finished level (high = idle).
busy  output  1  FSM not in IDLE, or FIFO not empty.
fifo_level  output  $clog2(DEPTH)+1  words currently queued.
overflow  output  1  sticky: a push was attempted while the FIFO was full.
timeout_err  output  1  sticky: enc_done never fell within START_TIMEOUT.

Behaviour:
- Reset is applied when reset=0 at a clk edge. It clears FIFO pointers and count, sets the FSM to IDLE, zeroes the repeat and gap counters, and clears the sticky flags.
- Output values during reset: enc_ld=0, enc_ad=0, in_ready=1, busy=0, fifo_level=0, overflow=0, timeout_err=0.
- Reset mid-frame: enc_ld is low from the next cycle. This block does not reset pt_enc.
- FIFO:
  - Circular buffer with a separate count.
  - Push when in_valid && in_ready.
  - in_ready is derived only from count<DEPTH. A pop in the same cycle does not free a slot for a push into a full FIFO.
  - in_valid with in_ready=0: word dropped, overflow set.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance, wrap modulo DEPTH.
- FSM:
  - IDLE: if count>0, pop the head into the word register. Load rep_cnt with cfg_repeats, or DEF_REPEATS if cfg_repeats=0. Go to LOAD.
  - LOAD: enc_ld=1 for exactly one cycle; enc_ad=word. Clear the timer. Go to WAIT_START.
  - WAIT_START:
    - If enc_done=0, go to WAIT_DONE.
    - Otherwise increment the timer. When the timer reaches START_TIMEOUT: set timeout_err, discard the remaining repeats of this word, go to IDLE.
  - WAIT_DONE: when enc_done=1, decrement rep_cnt, clear the gap counter, go to GAP.
  - GAP: count GAP_CYCLES clocks. Then go to LOAD if rep_cnt>0, otherwise go to IDLE.
- Latency: with the FIFO empty and the FSM in IDLE, in_valid at cycle 0 produces enc_ld high in cycle 2.
- Spacing between launches: enc_ld pulses for the same word are separated by at least GAP_CYCLES+2 clocks after enc_done rises.
- Ordering: words leave the FIFO strictly in arrival order; there is no reordering or merging.
- enc_ld is never asserted in WAIT_START, WAIT_DONE, GAP or IDLE.
- Sticky flags clear only on reset.

Test Plan:
- Single word, cfg_repeats=0: push 0xAAAAAA; a bench model of pt_enc drops done for 100 cycles per frame -> exactly 4 enc_ld pulses, each with enc_ad=0xAAAAAA, each preceded by ≥32 cycles of gap after done rises; busy then falls.
- Latency: push 0x000001 while in IDLE with the FIFO empty -> enc_ld high exactly 2 cycles after in_valid; cfg_repeats=1 gives exactly one pulse.
- Full/overflow, DEPTH=4, encoder stalled: push 0x000001 and, after it is dequeued, push 5 more words (0x000002–0x000006) -> fifo_level reaches 4, in_ready=0, the 6th push (0x000006) is dropped and overflow=1. On release, words 0x000002–0x000005 launch in order.
- Wrap-around: push/launch 10 words through DEPTH=4 with interleaved pushes and pops -> enc_ad sequence matches push order; fifo_level is never wrong at a simultaneous push/pop.
- Timeout: hold enc_done=1 permanently after enc_ld -> timeout_err=1 at 64 cycles, the FSM returns to IDLE, and the next queued word launches.
- Reset mid-operation: assert reset=0 during WAIT_DONE with 2 words queued -> next cycle enc_ld=0, fifo_level=0, busy=0; after release, no stale launches occur.

Source files
------------

// File: rtl/pt_tx_sched_if.sv
// Handshake bundle between the code-word assembler, the transmission
// scheduler and the PT2262 encoder. The scheduler uses the slave view; the
// environment (assembler plus encoder) uses the master view.
interface pt_tx_sched_if;
   logic        in_valid;
   logic [23:0] in_data;
   logic        in_ready;
   logic [3:0]  cfg_repeats;
   logic        enc_ld;
   logic [23:0] enc_ad;
   logic        enc_done;

   modport master (
      output in_valid, in_data, cfg_repeats, enc_done,
      input  in_ready, enc_ld, enc_ad
   );

   modport slave (
      input  in_valid, in_data, cfg_repeats, enc_done,
      output in_ready, enc_ld, enc_ad
   );
endinterface

// File: rtl/pt_tx_sched.sv
// Transmission scheduler: queues assembled 24-bit code words and launches
// each one into the PT2262 encoder several times, with an idle gap between
// launches, because PT2262 receivers only accept repeated frames.
module pt_tx_sched #(
   parameter int DEPTH         = 4,
   parameter int DEF_REPEATS   = 4,
   parameter int GAP_CYCLES    = 32,
   parameter int START_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   pt_tx_sched_if.slave           bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   overflow,
   output logic                   timeout_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_C     = TW'(START_TIMEOUT);
   localparam logic [GW-1:0] GAP_C     = GW'(GAP_CYCLES);
   localparam logic [3:0]    DEF_REP_C = 4'(DEF_REPEATS);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LOAD       = 3'd1;
   localparam logic [2:0] S_WAIT_START = 3'd2;
   localparam logic [2:0] S_WAIT_DONE  = 3'd3;
   localparam logic [2:0] S_GAP        = 3'd4;

   logic [23:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [2:0]    state_q, state_d;
   logic [23:0]   word_q, word_d;
   logic [3:0]    rep_q, rep_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          ovf_q;
   logic          tmo_q, tmo_d;
   logic          push, pop;

   // Readiness depends on the stored count only, so a pop in the same cycle
   // never opens a slot in a full FIFO.
   assign bus.in_ready = (count_q < FULL_C);
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (state_q == S_IDLE) && (count_q != '0);

   // Word storage; written on every accepted push.
   // NOTE: the storage array has no reset -- pointers and count define which
   // entries are valid, so clearing the data itself buys nothing.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end

   // FIFO pointers, occupancy count and the sticky overflow flag.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.in_valid && !bus.in_ready) ovf_q <= 1'b1;
      end
   end

   // Launch sequencer: dequeue, load, wait for the encoder to start and
   // finish, then hold off for the gap before the next repeat.
   // NOTE: every next-state variable gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      rep_d   = rep_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               word_d  = mem_q[rd_ptr_q];
               rep_d   = (bus.cfg_repeats == 4'd0) ? DEF_REP_C : bus.cfg_repeats;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            timer_d = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!bus.enc_done) begin
               state_d = S_WAIT_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_d == TMO_C) begin
                  // Encoder never started: abandon the remaining repeats.
                  tmo_d   = 1'b1;
                  rep_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (bus.enc_done) begin
               rep_d   = rep_q - 1'b1;
               gap_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            // The gap counter runs through GAP_CYCLES idle clocks and decides
            // on the following one, giving GAP_CYCLES+2 clocks from done to
            // the next load.
            if (gap_q == GAP_C) begin
               state_d = (rep_q != '0) ? S_LOAD : S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer registers and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         rep_q   <= '0;
         timer_q <= '0;
         gap_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         rep_q   <= rep_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.enc_ld  = (state_q == S_LOAD);
   assign bus.enc_ad  = word_q;
   assign busy        = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_level  = count_q;
   assign overflow    = ovf_q;
   assign timeout_err = tmo_q;
endmodule
